// File: rtl/ram_fifo_ctrl.sv
// Byte FIFO sequencer in front of a single-port RAM (combinational read, synchronous write).
// Zero-fills the array after reset; optional occupancy outputs under FIFO_LEVEL_EN.
module ram_fifo_ctrl #(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push_valid,
    output logic              push_ready,
    input  logic [7:0]        push_data,
    output logic              pop_valid,
    input  logic              pop_ready,
    output logic [7:0]        pop_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_data,
    output logic              mem_rw,
    output logic              mem_en,
    input  logic [7:0]        mem_q
`ifdef FIFO_LEVEL_EN
    ,
    output logic [ADDR_W:0]   level,
    output logic              almost_full
`endif
);

    localparam logic [ADDR_W-1:0] LAST   = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   FULL   = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   ALMOST = (ADDR_W + 1)'(DEPTH - 1);

    typedef enum logic {CLEAR, RUN} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] clr_cnt;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   mem_count, count_nxt;
    logic              rd_grant, wr_grant;
    logic              vld_p1, vld_nxt;
    logic [7:0]        pop_data_p1;

    function automatic logic [ADDR_W-1:0] ptr_inc(input logic [ADDR_W-1:0] p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) state <= CLEAR;
        else     state <= state_nxt;
    end

    // Grants, RAM port drive and next occupancy; read wins over write.
    always_comb begin
        state_nxt  = state;
        rd_grant   = 1'b0;
        wr_grant   = 1'b0;
        push_ready = 1'b0;
        mem_en     = 1'b0;
        mem_rw     = 1'b1;
        mem_addr   = '0;
        mem_data   = '0;
        count_nxt  = mem_count;
        vld_nxt    = vld_p1;
        if (!rst) begin
            if (state == CLEAR) begin
                mem_en   = 1'b1;
                mem_rw   = 1'b0;
                mem_addr = clr_cnt;
                if (clr_cnt == LAST) state_nxt = RUN;
            end else begin
                rd_grant   = (mem_count != '0) && (!vld_p1 || pop_ready);
                push_ready = !rd_grant && (mem_count < FULL);
                wr_grant   = push_valid && push_ready;
                if (rd_grant) begin
                    mem_en    = 1'b1;
                    mem_addr  = rd_ptr;
                    count_nxt = mem_count - 1'b1;
                    vld_nxt   = 1'b1;
                end else if (wr_grant) begin
                    mem_en    = 1'b1;
                    mem_rw    = 1'b0;
                    mem_addr  = wr_ptr;
                    mem_data  = push_data;
                    count_nxt = mem_count + 1'b1;
                end
                if (!rd_grant && vld_p1 && pop_ready) vld_nxt = 1'b0;
            end
        end
    end

    // Stage p1: pointers, occupancy and the registered head byte
    always_ff @(posedge clk) begin
        if (rst) begin
            clr_cnt     <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            mem_count   <= '0;
            vld_p1      <= 1'b0;
            pop_data_p1 <= '0;
        end else if (state == CLEAR) begin
            clr_cnt <= clr_cnt + 1'b1;
        end else begin
            mem_count <= count_nxt;
            vld_p1    <= vld_nxt;
            if (wr_grant) wr_ptr <= ptr_inc(wr_ptr);
            if (rd_grant) begin
                rd_ptr      <= ptr_inc(rd_ptr);
                pop_data_p1 <= mem_q;
            end
        end
    end

    assign pop_valid = vld_p1;
    assign pop_data  = pop_data_p1;

`ifdef FIFO_LEVEL_EN
    logic [ADDR_W:0] level_p1;

    // Level counts the head register too, so it can reach DEPTH+1.
    always_ff @(posedge clk) begin
        if (rst || state == CLEAR) level_p1 <= '0;
        else                       level_p1 <= count_nxt + (ADDR_W + 1)'(vld_nxt);
    end

    assign level       = level_p1;
    assign almost_full = (level_p1 >= ALMOST);
`endif

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Directed bench for ram_fifo_ctrl with a behavioural 256x8 RAM behind it.
module tb_ram_fifo_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       push_valid = 1'b0;
    logic       push_ready;
    logic [7:0] push_data = 8'h00;
    logic       pop_valid;
    logic       pop_ready = 1'b0;
    logic [7:0] pop_data;
    logic [7:0] mem_addr;
    logic [7:0] mem_data;
    logic       mem_rw;
    logic       mem_en;
    logic [7:0] mem_q;
`ifdef FIFO_LEVEL_EN
    logic [8:0] level;
    logic       almost_full;
`endif

    ram_fifo_ctrl #(.DEPTH(256), .ADDR_W(8)) dut (
        .clk(clk), .rst(rst),
        .push_valid(push_valid), .push_ready(push_ready), .push_data(push_data),
        .pop_valid(pop_valid), .pop_ready(pop_ready), .pop_data(pop_data),
        .mem_addr(mem_addr), .mem_data(mem_data), .mem_rw(mem_rw), .mem_en(mem_en),
        .mem_q(mem_q)
`ifdef FIFO_LEVEL_EN
        , .level(level), .almost_full(almost_full)
`endif
    );

    always #5 clk = ~clk;

    // RAM model; poisoned with 0xFF at start so the zero-fill is observable
    logic [7:0] ram [256];
    logic       poison = 1'b1;
    always @(posedge clk) begin
        if (poison) begin
            for (int k = 0; k < 256; k++) ram[k] <= 8'hFF;
        end else if (mem_en && !mem_rw) begin
            ram[mem_addr] <= mem_data;
        end
    end
    assign mem_q = ram[mem_addr];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] d, input string tag);
        int w = 0;
        push_valid = 1'b1;
        push_data  = d;
        #1;
        while (!push_ready && w < 600) begin
            step;
            #1;
            w++;
        end
        chk(tag, int'(push_ready), 1);
        step;
        push_valid = 1'b0;
    endtask

    task automatic run_clear(output int writes, output int errs, output int first_rdy, output int pv);
        writes = 0; errs = 0; first_rdy = 0; pv = 0;
        for (int i = 1; i <= 260; i++) begin
            #1;
            if (mem_en && !mem_rw) begin
                if (mem_addr != 8'(writes) || mem_data != 8'h00) errs++;
                writes++;
            end
            if (push_ready && first_rdy == 0) first_rdy = i;
            if (pop_valid) pv++;
            step;
        end
    endtask

    function automatic int ram_nonzero();
        int n = 0;
        for (int k = 0; k < 256; k++) if (ram[k] != 8'h00) n++;
        return n;
    endfunction

    initial begin
        int wr, er, fr, pv, acc, got, err;
        int sent, rcv, last_w, last_r, perr;
        bit ww, rw, take;
        int acc_at;
        logic [7:0] q[$];
        logic [7:0] exp_conf [6];

        // reset behaviour
        step;
        poison = 1'b0;
        chk("rst_mem_en", int'(mem_en), 0);
        chk("rst_mem_rw", int'(mem_rw), 1);
        chk("rst_mem_addr", int'(mem_addr), 0);
        chk("rst_mem_data", int'(mem_data), 0);
        chk("rst_push_ready", int'(push_ready), 0);
        chk("rst_pop_valid", int'(pop_valid), 0);
        chk("rst_pop_data", int'(pop_data), 0);
        step;
        rst = 1'b0;
        run_clear(wr, er, fr, pv);
        chk("clr_writes", wr, 256);
        chk("clr_order", er, 0);
        chk("clr_first_ready", fr, 257);
        chk("clr_pop_valid", pv, 0);
        chk("clr_ram_zero", ram_nonzero(), 0);
`ifdef FIFO_LEVEL_EN
        chk("clr_level", int'(level), 0);
        chk("clr_almost_full", int'(almost_full), 0);
`endif

        // single byte through an empty FIFO
        push_valid = 1'b1; push_data = 8'hA5; pop_ready = 1'b1;
        #1;
        chk("sb_push_ready", int'(push_ready), 1);
        chk("sb_wr_en", int'(mem_en), 1);
        chk("sb_wr_rw", int'(mem_rw), 0);
        chk("sb_wr_addr", int'(mem_addr), 0);
        chk("sb_wr_data", int'(mem_data), 8'hA5);
        step;
        push_valid = 1'b0;
        #1;
        chk("sb_rd_en", int'(mem_en), 1);
        chk("sb_rd_rw", int'(mem_rw), 1);
        chk("sb_rd_addr", int'(mem_addr), 0);
        chk("sb_rd_pop_valid", int'(pop_valid), 0);
        step;
        chk("sb_pop_valid", int'(pop_valid), 1);
        chk("sb_pop_data", int'(pop_data), 8'hA5);
`ifdef FIFO_LEVEL_EN
        chk("sb_level", int'(level), 1);
`endif
        step;
        chk("sb_pop_valid_off", int'(pop_valid), 0);

        // fill to capacity with the consumer stalled
        pop_ready = 1'b0; push_valid = 1'b1; acc = 0;
        for (int i = 0; i < 400; i++) begin
            push_data = 8'(acc);
            #1;
            if (push_ready) acc++;
            step;
        end
        #1;
        chk("fill_accepted", acc, 257);
        chk("fill_push_ready", int'(push_ready), 0);
        chk("fill_pop_valid", int'(pop_valid), 1);
        chk("fill_pop_data", int'(pop_data), 0);
`ifdef FIFO_LEVEL_EN
        chk("fill_level", int'(level), 257);
        chk("fill_almost_full", int'(almost_full), 1);
`endif
        push_valid = 1'b0; pop_ready = 1'b1; got = 0; err = 0;
        for (int i = 0; i < 400; i++) begin
            #1;
            if (pop_valid) begin
                if (pop_data != 8'(got)) err++;
                got++;
            end
            step;
        end
        chk("drain_count", got, 257);
        chk("drain_order", err, 0);
        chk("drain_pop_valid", int'(pop_valid), 0);

        // wrap-around with a consumer ready every other cycle
        sent = 0; rcv = 0; err = 0; perr = 0; last_w = -1; last_r = -1; ww = 0; rw = 0;
        for (int c = 0; c < 3000 && rcv < 300; c++) begin
            pop_ready  = (c % 2) == 1;
            push_valid = sent < 300;
            push_data  = 8'(sent);
            #1;
            if (mem_en && !mem_rw) begin
                if (last_w == 255 && mem_addr == 8'd0) ww = 1;
                if (last_w >= 0 && mem_addr != 8'(last_w + 1)) perr++;
                last_w = int'(mem_addr);
            end else if (mem_en) begin
                if (last_r == 255 && mem_addr == 8'd0) rw = 1;
                if (last_r >= 0 && mem_addr != 8'(last_r + 1)) perr++;
                last_r = int'(mem_addr);
            end
            if (push_valid && push_ready) sent++;
            if (pop_valid && pop_ready) begin
                if (pop_data != 8'(rcv)) err++;
                rcv++;
            end
            step;
        end
        push_valid = 1'b0; pop_ready = 1'b0;
        chk("wrap_sent", sent, 300);
        chk("wrap_received", rcv, 300);
        chk("wrap_order", err, 0);
        chk("wrap_ptr_step", perr, 0);
        chk("wrap_wr_ptr", int'(ww), 1);
        chk("wrap_rd_ptr", int'(rw), 1);

        // read/write conflict: reads win until the store is empty
        for (int k = 0; k < 5; k++) push_byte(8'h10 + 8'(k), "conf_load");
        #1;
        chk("conf_pop_valid", int'(pop_valid), 1);
        chk("conf_head", int'(pop_data), 8'h10);
        push_valid = 1'b1; push_data = 8'h55; pop_ready = 1'b1;
        #1;
        chk("conf_push_blocked", int'(push_ready), 0);
        chk("conf_rd_granted", int'(mem_en && mem_rw), 1);
        acc_at = -1;
        for (int c = 0; c < 50; c++) begin
            #1;
            if (pop_valid && pop_ready) q.push_back(pop_data);
            take = push_valid && push_ready;
            if (take) acc_at = c;
            step;
            if (take) push_valid = 1'b0;
        end
        push_valid = 1'b0;
        chk("conf_accept_cycle", acc_at, 4);
        chk("conf_pop_count", q.size(), 6);
        exp_conf = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h55};
        for (int k = 0; k < 6 && k < q.size(); k++) chk("conf_order", int'(q[k]), int'(exp_conf[k]));

        // reset in the middle of traffic
        pop_ready = 1'b0;
        for (int k = 0; k < 10; k++) push_byte(8'hC0 + 8'(k), "mid_load");
        rst = 1'b1;
        #1;
        chk("mid_rst_mem_en", int'(mem_en), 0);
        step;
        rst = 1'b0;
        #1;
        chk("mid_pop_valid", int'(pop_valid), 0);
        chk("mid_clr_addr", int'(mem_addr), 0);
        chk("mid_clr_write", int'(mem_en && !mem_rw), 1);
        chk("mid_push_ready", int'(push_ready), 0);
`ifdef FIFO_LEVEL_EN
        chk("mid_level", int'(level), 0);
`endif
        run_clear(wr, er, fr, pv);
        chk("mid_clr_writes", wr, 256);
        chk("mid_clr_order", er, 0);
        chk("mid_clr_first_ready", fr, 257);
        chk("mid_ram_zero", ram_nonzero(), 0);
        pop_ready = 1'b1; pv = 0;
        for (int i = 0; i < 30; i++) begin
            #1;
            if (pop_valid) pv++;
            step;
        end
        chk("mid_no_old_bytes", pv, 0);
        push_byte(8'h3C, "mid_push");
        got = 0;
        for (int i = 0; i < 10 && got == 0; i++) begin
            #1;
            if (pop_valid) got = 1;
            else step;
        end
        chk("mid_after_valid", got, 1);
        chk("mid_after_data", int'(pop_data), 8'h3C);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
